// File: rtl/enc_pkg.sv
// enc_pkg
//   Shared definitions for the one-hot decoder / bit-encoder family.
//   - state_t : two-state serializer encoding (ST_IDLE, ST_EMIT)
//   - vec_width(n) : request vector width for an n-bit index (1 << n)
package enc_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   function automatic int vec_width(input int n);
      return 1 << n;
   endfunction

endpackage : enc_pkg

// File: rtl/decoder.sv
// decoder
//   Binary-to-one-hot decoder.
//   Ports:
//     a_i  in  N   binary index
//     y_o  out W   one-hot vector with bit a_i set (W = 1 << N)
module decoder
   import enc_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]      a_i,
   output logic [(1<<N)-1:0] y_o
);

   localparam int W = vec_width(N);

   always_comb begin
      y_o = '0;
      for (int i = 0; i < W; i++) begin
         y_o[i] = (a_i == i[N-1:0]);
      end
   end

endmodule : decoder

// File: rtl/prio_enc.sv
// prio_enc
//   Combinational lowest-set-bit finder.
//   Ports:
//     vec_i  in  W   vector to scan (W = 1 << N)
//     idx_o  out N   index of the lowest set bit (0 when vec_i is all-zero)
//     any_o  out 1   at least one bit of vec_i is set
module prio_enc
   import enc_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [(1<<N)-1:0] vec_i,
   output logic [N-1:0]      idx_o,
   output logic              any_o
);

   localparam int W = vec_width(N);

   // Scanning from the top down lets the lowest set bit win the last assignment.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = i[N-1:0];
            any_o = 1'b1;
         end
      end
   end

endmodule : prio_enc

// File: rtl/seq_bit_encoder.sv
// seq_bit_encoder
//   Captures a multi-hot request vector and returns the index of each set bit,
//   one per output handshake, in priority order (LSB-first or MSB-first).
//   An all-zero vector produces a single dummy beat flagged by out_zero.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are both
//   high. valid never depends combinationally on ready, and once out_valid is
//   raised it, out_idx, out_last and out_zero stay stable until the beat transfers.
//
//   Ports:
//     clk        in  1   clock, rising edge
//     rst        in  1   synchronous active-high reset
//     in_valid   in  1   in_vec is valid
//     in_ready   out 1   a vector can be captured this cycle
//     in_vec     in  W   multi-hot request vector (W = 1 << N)
//     out_valid  out 1   out_idx/out_last/out_zero are valid
//     out_ready  in  1   consumer accepts the current index
//     out_idx    out N   index of the highest-priority pending bit
//     out_last   out 1   final beat for the captured vector
//     out_zero   out 1   captured vector was all-zero
//     dbg_state  out 1   current FSM state (state_t encoding)
module seq_bit_encoder
   import enc_pkg::*;
#(
   parameter int N         = 2,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [(1<<N)-1:0] in_vec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_idx,
   output logic              out_last,
   output logic              out_zero,
   output logic              dbg_state
);

   localparam int         W   = vec_width(N);
   localparam logic [W-1:0] ONE = W'(1);

   state_t         state_q, state_d;
   logic [W-1:0]   pending_q, pending_d;
   logic           zero_q, zero_d;
   logic           init_q;

   logic [W-1:0]   scan_vec;
   logic [N-1:0]   scan_idx;
   logic [N-1:0]   prio_idx;
   logic           scan_any;
   logic [W-1:0]   clr_mask;
   logic           single_left;
   logic           emit;

   // MSB-first priority reuses the lowest-bit finder on the bit-reversed vector;
   // reversing position i maps to W-1-i, which is ~i for a power-of-two width.
   generate
      if (LSB_FIRST) begin : g_lsb
         assign scan_vec = pending_q;
         assign prio_idx = scan_idx;
      end else begin : g_msb
         for (genvar i = 0; i < W; i++) begin : g_rev
            assign scan_vec[i] = pending_q[W-1-i];
         end
         assign prio_idx = ~scan_idx;
      end
   endgenerate

   prio_enc #(.N(N)) u_prio (
      .vec_i (scan_vec),
      .idx_o (scan_idx),
      .any_o (scan_any)
   );

   decoder #(.N(N)) u_dec (
      .a_i (out_idx),
      .y_o (clr_mask)
   );

   // At most one bit pending: clearing the lowest set bit leaves nothing.
   assign single_left = ((pending_q & (pending_q - ONE)) == '0);
   assign emit        = (state_q == ST_EMIT);

   // All outputs come from registered state only. init_q holds in_ready low
   // during reset and releases it on the first edge with rst low.
   assign out_valid = emit;
   assign out_idx   = (emit && scan_any) ? prio_idx : '0;
   assign out_last  = emit && single_left;
   assign out_zero  = emit && zero_q;
   assign in_ready  = !emit && init_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      zero_d    = zero_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               pending_d = in_vec;
               zero_d    = (in_vec == '0);
               state_d   = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               // For a zero vector this clears bit 0, which is already clear.
               pending_d = pending_q & ~clr_mask;
               if (single_left) begin
                  state_d = ST_IDLE;
                  zero_d  = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         zero_q    <= 1'b0;
         init_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         zero_q    <= zero_d;
         init_q    <= 1'b1;
      end
   end

endmodule : seq_bit_encoder

// File: tb/tb_seq_bit_encoder.sv
module tb_seq_bit_encoder;
   import enc_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 0: N=2 LSB-first, instance 1: N=2 MSB-first, instance 2: N=3 LSB-first
   logic       a_rst, a_iv, a_ir, a_ov, a_or, a_last, a_zero, a_st;
   logic [3:0] a_vec;
   logic [1:0] a_idx;
   logic       b_rst, b_iv, b_ir, b_ov, b_or, b_last, b_zero, b_st;
   logic [3:0] b_vec;
   logic [1:0] b_idx;
   logic       c_rst, c_iv, c_ir, c_ov, c_or, c_last, c_zero, c_st;
   logic [7:0] c_vec;
   logic [2:0] c_idx;

   seq_bit_encoder #(.N(2), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_vec(a_vec),
      .out_valid(a_ov), .out_ready(a_or), .out_idx(a_idx), .out_last(a_last),
      .out_zero(a_zero), .dbg_state(a_st));

   seq_bit_encoder #(.N(2), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_vec(b_vec),
      .out_valid(b_ov), .out_ready(b_or), .out_idx(b_idx), .out_last(b_last),
      .out_zero(b_zero), .dbg_state(b_st));

   seq_bit_encoder #(.N(3), .LSB_FIRST(1'b1)) dut_c (
      .clk(clk), .rst(c_rst), .in_valid(c_iv), .in_ready(c_ir), .in_vec(c_vec),
      .out_valid(c_ov), .out_ready(c_or), .out_idx(c_idx), .out_last(c_last),
      .out_zero(c_zero), .dbg_state(c_st));

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [2:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input logic iv, input logic [7:0] vec,
                        input logic ordy);
      case (which)
         0: begin a_iv = iv; a_vec = vec[3:0]; a_or = ordy; end
         1: begin b_iv = iv; b_vec = vec[3:0]; b_or = ordy; end
         default: begin c_iv = iv; c_vec = vec; c_or = ordy; end
      endcase
   endtask

   task automatic sample(input int which, output logic ir, output logic ov,
                         output logic [2:0] idx, output logic last, output logic zero);
      case (which)
         0: begin ir = a_ir; ov = a_ov; idx = {1'b0, a_idx}; last = a_last; zero = a_zero; end
         1: begin ir = b_ir; ov = b_ov; idx = {1'b0, b_idx}; last = b_last; zero = b_zero; end
         default: begin ir = c_ir; ov = c_ov; idx = c_idx; last = c_last; zero = c_zero; end
      endcase
   endtask

   // Reference model: list of set-bit indices in priority order; an all-zero
   // vector yields a single index 0.
   task automatic build_expected(input logic [7:0] vec, input int n, input bit lsb,
                                 output bit is_zero);
      int w;
      int b;
      w = 1 << n;
      exp_q.delete();
      for (int k = 0; k < w; k++) begin
         b = lsb ? k : (w - 1 - k);
         if (vec[b]) exp_q.push_back(3'(b));
      end
      is_zero = (exp_q.size() == 0);
      if (is_zero) exp_q.push_back(3'd0);
   endtask

   // Full transaction: capture vec, drain all beats with out_ready high pct% of
   // cycles, then confirm the idle cycle that follows the last beat.
   task automatic run_tx(input int which, input logic [7:0] vec, input int pct);
      logic ir, ov, last, zero, r;
      logic [2:0] idx;
      bit   is_zero;
      int   guard;
      build_expected(vec, (which == 2) ? 3 : 2, (which != 1), is_zero);
      repeat ($urandom_range(0, 2)) begin
         drive(which, 1'b0, 8'($urandom), 1'b0);
         step();
      end
      guard = 0;
      sample(which, ir, ov, idx, last, zero);
      while (!ir && guard < 20) begin
         step();
         guard++;
         sample(which, ir, ov, idx, last, zero);
      end
      chk("in_ready_before_capture", ir, 1);
      drive(which, 1'b1, vec, 1'b0);
      step();
      drive(which, 1'b0, 8'($urandom), 1'b0);
      guard = 0;
      while (exp_q.size() > 0) begin
         if (guard > 300) begin
            chk("beat_timeout", 0, 1);
            exp_q.delete();
            break;
         end
         sample(which, ir, ov, idx, last, zero);
         chk("out_valid", ov, 1);
         chk("out_idx", idx, exp_q[0]);
         chk("out_last", last, (exp_q.size() == 1));
         chk("out_zero", zero, is_zero);
         chk("in_ready_busy", ir, 0);
         r = ($urandom_range(0, 99) < pct);
         drive(which, 1'b0, 8'($urandom), r);
         step();
         guard++;
         if (r) void'(exp_q.pop_front());
      end
      drive(which, 1'b0, 8'($urandom), 1'b0);
      sample(which, ir, ov, idx, last, zero);
      chk("out_valid_after_last", ov, 0);
      chk("in_ready_after_last", ir, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] exp_seq[4];
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      drive(0, 1'b0, 8'h0, 1'b0);
      drive(1, 1'b0, 8'h0, 1'b0);
      drive(2, 1'b0, 8'h0, 1'b0);

      // 1: reset behaviour
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_out_valid", a_ov, 0);
         chk("rst_in_ready", a_ir, 0);
         chk("rst_out_idx", a_idx, 0);
         chk("rst_out_last", a_last, 0);
         chk("rst_out_zero", a_zero, 0);
         chk("rst_state", a_st, ST_IDLE);
      end
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      step();
      chk("in_ready_after_rst", a_ir, 1);
      chk("out_valid_after_rst", a_ov, 0);

      // 2: LSB-first 1011 -> 0,1,3
      run_tx(0, 8'b1011, 100);
      // 3: MSB-first 1011 -> 3,1,0
      run_tx(1, 8'b1011, 100);

      // 4: stall with a competing vector held on the input
      drive(0, 1'b1, 8'b0110, 1'b0);
      step();
      drive(0, 1'b1, 8'b1111, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_idx", a_idx, 1);
         chk("stall_valid", a_ov, 1);
         chk("stall_last", a_last, 0);
         chk("stall_in_ready", a_ir, 0);
         step();
      end
      drive(0, 1'b1, 8'b1111, 1'b1);
      chk("stall_release_idx", a_idx, 1);
      step();
      chk("second_idx", a_idx, 2);
      chk("second_last", a_last, 1);
      step();
      drive(0, 1'b1, 8'b1111, 1'b0);
      chk("gap_out_valid", a_ov, 0);
      chk("gap_in_ready", a_ir, 1);
      step();
      drive(0, 1'b0, 8'b0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_seq[i] = 2'(i);
         chk("late_capture_valid", a_ov, 1);
         chk("late_capture_idx", a_idx, exp_seq[i]);
         step();
      end
      drive(0, 1'b0, 8'b0000, 1'b0);
      chk("late_capture_done", a_ov, 0);

      // 5: zero vector
      run_tx(0, 8'b0000, 100);

      // 6: reset mid-emit
      drive(0, 1'b1, 8'b1111, 1'b0);
      step();
      drive(0, 1'b0, 8'b0000, 1'b1);
      chk("pre_rst_idx", a_idx, 0);
      step();
      chk("pre_rst_idx2", a_idx, 1);
      a_rst = 1'b1;
      step();
      chk("rst_mid_out_valid", a_ov, 0);
      chk("rst_mid_in_ready", a_ir, 0);
      a_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_no_beat", a_ov, 0);
      end
      drive(0, 1'b0, 8'b0000, 1'b0);
      run_tx(0, 8'b1000, 100);

      // random N=2 traffic on both priority orders
      for (int i = 0; i < 20; i++) begin
         run_tx(0, 8'($urandom_range(0, 15)), 50);
         run_tx(1, 8'($urandom_range(0, 15)), 50);
      end

      // N=3 exhaustive sweep with random out_ready
      for (int v = 0; v < 256; v++) begin
         run_tx(2, 8'(v), 60);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_seq_bit_encoder
